// File: rtl/score_disp_pkg.sv
// Shared constants, converter state encoding and seven-segment lookup for score_display.
package score_disp_pkg;

    localparam int unsigned BCD_MAX   = 9999;
    localparam int unsigned CONV_BITS = 14;

    // Active-low segments, bit order GFEDCBA.
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic [1:0] {
        CONV_IDLE,
        CONV_LOAD,
        CONV_SHIFT,
        CONV_DONE
    } conv_state_t;

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/score_display_bin2bcd.sv
// Sequential double-dabble converter: 14-bit binary to four BCD digits, 16 cycles start-to-done.
module bin2bcd_seq
    import score_disp_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [CONV_BITS-1:0] bin,
    output logic                 busy,
    output logic                 done,
    output logic [15:0]          bcd
);

    conv_state_t          state, state_next;
    logic [CONV_BITS-1:0] bin_sr;
    logic [15:0]          bcd_sr;
    logic [15:0]          bcd_adj;
    logic [3:0]           count;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= CONV_IDLE;
        else       state <= state_next;
    end

    // Next-state logic; start is only honoured while idle.
    always_comb begin
        state_next = state;
        case (state)
            CONV_IDLE:  if (start) state_next = CONV_LOAD;
            CONV_LOAD:  state_next = CONV_SHIFT;
            CONV_SHIFT: if (count == 4'(CONV_BITS - 1)) state_next = CONV_DONE;
            CONV_DONE:  state_next = CONV_IDLE;
            default:    state_next = CONV_IDLE;
        endcase
    end

    // Add-3 correction on every BCD nibble of 5 or more before the shift.
    always_comb begin
        bcd_adj = bcd_sr;
        for (int unsigned i = 0; i < 4; i++) begin
            if (bcd_sr[i*4 +: 4] >= 4'd5) bcd_adj[i*4 +: 4] = bcd_sr[i*4 +: 4] + 4'd3;
        end
    end

    // Shift datapath: load clears the BCD side, each SHIFT cycle moves one binary bit in.
    always_ff @(posedge clk) begin
        if (reset) begin
            bin_sr <= '0;
            bcd_sr <= '0;
            count  <= '0;
        end else begin
            case (state)
                CONV_LOAD: begin
                    bin_sr <= bin;
                    bcd_sr <= '0;
                    count  <= '0;
                end
                CONV_SHIFT: begin
                    {bcd_sr, bin_sr} <= {bcd_adj, bin_sr} << 1;
                    count            <= count + 4'd1;
                end
                default: ;
            endcase
        end
    end

    assign busy = (state != CONV_IDLE);
    assign done = (state == CONV_DONE);
    assign bcd  = bcd_sr;

endmodule

// File: rtl/score_display.sv
// Best-time tracker, shared BCD conversion sequencer and 8-digit multiplexed display driver.
module score_display
    import score_disp_pkg::*;
#(
    parameter int unsigned DIGIT_TICKS = 100000,
    parameter int unsigned TIMER_W     = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [TIMER_W-1:0] timer,
    input  logic               won_the_game,
    input  logic               hit_a_hole,
    output logic [6:0]         seg,
    output logic               dp,
    output logic [7:0]         an,
    output logic [TIMER_W-1:0] best_time,
    output logic               new_record
);

    localparam int unsigned SCAN_W = $clog2(DIGIT_TICKS);

    logic                 won_d;
    logic                 win;
    logic                 best_valid;
    logic                 sel_best;
    logic                 start_conv;
    logic                 conv_busy;
    logic                 conv_done;
    logic [15:0]          conv_bcd;
    logic [CONV_BITS-1:0] cur_clamped;
    logic [CONV_BITS-1:0] best_clamped;
    logic [CONV_BITS-1:0] conv_bin;
    logic [15:0]          shown_cur;
    logic [15:0]          shown_best;
    logic [SCAN_W-1:0]    scan_cnt;
    logic [2:0]           idx;
    logic [6:0]           digit_seg;

    // A restart after a hole does not touch the record, so hit_a_hole is not consulted.
    logic unused_hole;
    assign unused_hole = hit_a_hole;

    assign win = won_the_game & ~won_d;

    // Best-time tracker: rising edge of won, strictly lower time (or first win) updates.
    always_ff @(posedge clk) begin
        if (reset) begin
            won_d      <= 1'b0;
            best_time  <= '0;
            best_valid <= 1'b0;
            new_record <= 1'b0;
        end else begin
            won_d      <= won_the_game;
            new_record <= 1'b0;
            if (win && (!best_valid || timer < best_time)) begin
                best_time  <= timer;
                best_valid <= 1'b1;
                new_record <= 1'b1;
            end
        end
    end

    // Saturate both values to four decimal digits before conversion.
    always_comb begin
        cur_clamped  = (timer > TIMER_W'(BCD_MAX)) ? CONV_BITS'(BCD_MAX) : timer[CONV_BITS-1:0];
        best_clamped = (best_time > TIMER_W'(BCD_MAX)) ? CONV_BITS'(BCD_MAX)
                                                       : best_time[CONV_BITS-1:0];
    end

    // sel_best only flips on done, so the operand stays stable through LOAD.
    assign conv_bin   = sel_best ? best_clamped : cur_clamped;
    assign start_conv = ~conv_busy;

    bin2bcd_seq u_conv (
        .clk   (clk),
        .reset (reset),
        .start (start_conv),
        .bin   (conv_bin),
        .busy  (conv_busy),
        .done  (conv_done),
        .bcd   (conv_bcd)
    );

    // Conversion sequencer: alternate current/best, latching each result as it completes.
    always_ff @(posedge clk) begin
        if (reset) begin
            sel_best   <= 1'b0;
            shown_cur  <= '0;
            shown_best <= '0;
        end else if (conv_done) begin
            if (sel_best) shown_best <= conv_bcd;
            else          shown_cur  <= conv_bcd;
            sel_best <= ~sel_best;
        end
    end

    // Scan timer: hold each digit DIGIT_TICKS cycles, then advance the digit index.
    always_ff @(posedge clk) begin
        if (reset) begin
            scan_cnt <= '0;
            idx      <= '0;
        end else if (scan_cnt == SCAN_W'(DIGIT_TICKS - 1)) begin
            scan_cnt <= '0;
            idx      <= idx + 3'd1;
        end else begin
            scan_cnt <= scan_cnt + SCAN_W'(1);
        end
    end

    // Digit mux: right half is the current time, left half the best time or a dash.
    always_comb begin
        digit_seg = SEG_BLANK;
        if (!idx[2])        digit_seg = seg_of(shown_cur[{idx[1:0], 2'b00} +: 4]);
        else if (best_valid) digit_seg = seg_of(shown_best[{idx[1:0], 2'b00} +: 4]);
        else                 digit_seg = SEG_DASH;
    end

    // Registered display outputs; decimal point before the tenths digit of each half.
    always_ff @(posedge clk) begin
        if (reset) begin
            an  <= '1;
            seg <= '1;
            dp  <= 1'b1;
        end else begin
            an  <= ~(8'b1 << idx);
            seg <= digit_seg;
            dp  <= ~(idx[1:0] == 2'd1);
        end
    end

endmodule

// File: tb/tb_score_display.sv
// Self-checking bench for score_display: win/record vector table plus scoreboarded display scans.
module tb_score_display;

    localparam int unsigned DT = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] timer;
    logic        won_the_game;
    logic        hit_a_hole;
    logic [6:0]  seg;
    logic        dp;
    logic [7:0]  an;
    logic [15:0] best_time;
    logic        new_record;

    score_display #(.DIGIT_TICKS(DT), .TIMER_W(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .timer        (timer),
        .won_the_game (won_the_game),
        .hit_a_hole   (hit_a_hole),
        .seg          (seg),
        .dp           (dp),
        .an           (an),
        .best_time    (best_time),
        .new_record   (new_record)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned timer;
        bit          win;
        bit          hole;
        int unsigned exp_best;
        bit          exp_pulse;
        bit          exp_valid;
    } vec_t;

    typedef struct {
        logic [6:0] seg;
        logic       dp;
    } exp_digit_t;

    logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                 7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

    exp_digit_t exp_q[$];
    vec_t       vecs[8];
    int         n_checks = 0;
    int         n_err    = 0;

    task automatic step(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    function automatic logic [6:0] digit_seg(input int unsigned val, input int unsigned k);
        int unsigned c = (val > 9999) ? 9999 : val;
        for (int unsigned i = 0; i < k; i++) c = c / 10;
        return seg_tab[c % 10];
    endfunction

    // Queue the eight expected digits, rightmost first.
    task automatic expect_display(input int unsigned cur, input int unsigned best, input bit valid);
        exp_digit_t e;
        for (int unsigned k = 0; k < 8; k++) begin
            if (k < 4)      e.seg = digit_seg(cur, k);
            else if (valid) e.seg = digit_seg(best, k - 4);
            else            e.seg = 7'b0111111;
            e.dp = (k == 1 || k == 5) ? 1'b0 : 1'b1;
            exp_q.push_back(e);
        end
    endtask

    // Align to the first cycle of digit 0 and pop/compare one queued entry per digit.
    task automatic check_scan(input string tag);
        int unsigned t = 0;
        exp_digit_t  e;
        while (an == 8'hFE && t < 64) begin step(1); t++; end
        while (an != 8'hFE && t < 64) begin step(1); t++; end
        if (an != 8'hFE) begin
            n_checks++;
            n_err++;
            $display("FAIL %s scan_sync: an=0x%0h, digit 0 never lit within 64 cycles", tag, an);
            repeat (8) void'(exp_q.pop_front());
            return;
        end
        for (int unsigned k = 0; k < 8; k++) begin
            e = exp_q.pop_front();
            chk($sformatf("%s an[%0d]", tag, k), {24'd0, an}, {24'd0, ~(8'b1 << k)});
            chk($sformatf("%s seg[%0d]", tag, k), {25'd0, seg}, {25'd0, e.seg});
            chk($sformatf("%s dp[%0d]", tag, k), {31'd0, dp}, {31'd0, e.dp});
            step(DT);
        end
    endtask

    initial begin
        int unsigned pulses;
        int unsigned lat;

        vecs[0] = '{1234,  1'b0, 1'b0, 0,   1'b0, 1'b0};
        vecs[1] = '{500,   1'b1, 1'b0, 500, 1'b1, 1'b1};
        vecs[2] = '{600,   1'b1, 1'b0, 500, 1'b0, 1'b1};
        vecs[3] = '{500,   1'b1, 1'b0, 500, 1'b0, 1'b1};
        vecs[4] = '{400,   1'b1, 1'b0, 400, 1'b1, 1'b1};
        vecs[5] = '{300,   1'b0, 1'b1, 400, 1'b0, 1'b1};
        vecs[6] = '{350,   1'b1, 1'b1, 350, 1'b1, 1'b1};
        vecs[7] = '{12000, 1'b0, 1'b0, 350, 1'b0, 1'b1};

        reset = 1'b1;
        timer = 16'd0;
        won_the_game = 1'b0;
        hit_a_hole = 1'b0;
        step(3);
        chk("reset an", {24'd0, an}, 32'hFF);
        chk("reset seg", {25'd0, seg}, 32'h7F);
        chk("reset dp", {31'd0, dp}, 32'd1);
        chk("reset best_time", {16'd0, best_time}, 32'd0);
        chk("reset new_record", {31'd0, new_record}, 32'd0);
        reset = 1'b0;
        chk("an before first scan", {24'd0, an}, 32'hFF);
        step(1);
        chk("an first scan", {24'd0, an}, 32'hFE);

        for (int v = 0; v < 8; v++) begin
            timer = 16'(vecs[v].timer);
            won_the_game = 1'b0;
            hit_a_hole = 1'b0;
            step(3);
            won_the_game = vecs[v].win;
            hit_a_hole = vecs[v].hole;
            step(1);
            hit_a_hole = 1'b0;
            chk($sformatf("v%0d best_time", v), {16'd0, best_time}, vecs[v].exp_best);
            chk($sformatf("v%0d new_record", v), {31'd0, new_record}, {31'd0, vecs[v].exp_pulse});
            step(1);
            chk($sformatf("v%0d pulse_end", v), {31'd0, new_record}, 32'd0);
            if (vecs[v].win) begin
                pulses = 0;
                for (int c = 0; c < 100; c++) begin
                    if (new_record) pulses++;
                    step(1);
                end
                chk($sformatf("v%0d held_won_pulses", v), pulses, 0);
                chk($sformatf("v%0d held_best", v), {16'd0, best_time}, vecs[v].exp_best);
            end
            step(70);
            expect_display(vecs[v].timer, vecs[v].exp_best, vecs[v].exp_valid);
            check_scan($sformatf("v%0d", v));
        end

        // First win after reset with an over-range time saturates on the display only.
        won_the_game = 1'b0;
        reset = 1'b1;
        step(2);
        reset = 1'b0;
        timer = 16'd12000;
        step(3);
        won_the_game = 1'b1;
        step(1);
        chk("sat best_time", {16'd0, best_time}, 32'd12000);
        chk("sat new_record", {31'd0, new_record}, 32'd1);
        step(80);
        expect_display(12000, 12000, 1'b1);
        check_scan("sat");

        // Reset in the middle of SHIFT, then time the first conversion afterwards.
        lat = 0;
        while (!dut.u_conv.done && lat < 40) begin step(1); lat++; end
        chk("midreset found_done", {31'd0, dut.u_conv.done}, 32'd1);
        step(6);
        chk("midreset busy", {31'd0, dut.u_conv.busy}, 32'd1);
        reset = 1'b1;
        step(1);
        chk("midreset an", {24'd0, an}, 32'hFF);
        chk("midreset best_time", {16'd0, best_time}, 32'd0);
        chk("midreset shown_cur", {16'd0, dut.shown_cur}, 32'd0);
        chk("midreset shown_best", {16'd0, dut.shown_best}, 32'd0);
        chk("midreset conv_idle", {31'd0, dut.u_conv.busy}, 32'd0);
        reset = 1'b0;
        chk("restart start_conv", {31'd0, dut.start_conv}, 32'd1);
        lat = 0;
        for (int c = 1; c <= 40; c++) begin
            step(1);
            if (dut.u_conv.done) begin
                lat = c;
                break;
            end
        end
        chk("restart conv_latency", lat, 16);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/score_display.md
Name: score_display

Overview:
- Downstream consumer of the 16-bit game timer (units of 0.1 s). Tracks the best (lowest) completion time across games and drives the 8-digit multiplexed seven-segment display.
- Right four digits show the current run time; left four digits show the best time.
- Binary-to-BCD conversion is sequential (double-dabble), shared between the two values.

Parameters:
- DIGIT_TICKS, 100000, clk cycles each digit is lit (1 kHz per digit at 100 MHz); minimum 2.
- TIMER_W, 16, width of timer input and best_time output.

Ports:
- clk  in  1  system clock, 100 MHz.
- reset  in  1  synchronous, active-high; clears all state.
- timer  in  16  current elapsed time in tenths of a second, from the timer stage.
- won_the_game  in  1  level, high once the maze is completed.
- hit_a_hole  in  1  level/pulse, ball fell in a hole; the run restarts.
- seg  out  7  cathodes, active-low; seg[0]=CA … seg[6]=CG.
- dp  out  1  decimal point, active-low.
- an  out  8  anodes, active-low; an[0] is the rightmost digit.
- best_time  out  16  best recorded time in tenths.
- new_record  out  1  one-cycle pulse when best_time is updated.

Behaviour:
- Reset values: an=8'hFF, seg=7'h7F, dp=1, best_time=0, best_valid=0, new_record=0. Digit index=0, scan counter=0, converter IDLE, both shown BCD registers=0.
- Win detect: won_d registers won_the_game. A win is the condition won_the_game & ~won_d.
- On a win, best_time<=timer and best_valid<=1 if best_valid==0 or timer<best_time. new_record=1 on the following cycle only.
- Equal time: no update and no pulse.
- won_the_game held high: no further updates.
- hit_a_hole has no effect on best_time.
- A win and hit_a_hole in the same cycle: the win is honoured using the sampled timer.
- Saturation: a value above 9999 is clamped to 9999 before conversion. The converter input is 14 bits.
- Converter FSM (bin2bcd_seq), states IDLE -> LOAD -> SHIFT -> DONE -> IDLE:
  - LOAD: capture bin, clear the BCD shift register.
  - SHIFT: 14 iterations, each adding 3 to any nibble ≥5, then shifting left 1.
  - DONE: assert done for one cycle with bcd[15:0] valid.
  - start is accepted only in IDLE. Total latency from start to done is 16 cycles.
- Top-level sequencing:
  - Conversions of current (clamped timer) and best (clamped best_time) are issued back-to-back, alternating forever.
  - Each done writes the matching shown register.
  - The display reflects any input change within 34 cycles.
- Scan:
  - The counter runs 0..DIGIT_TICKS-1. On wrap, the digit index increments 0..7 and wraps to 0.
  - an, seg and dp are registered and reflect the current index one cycle after it changes.
  - an=~(8'b1<<idx).
- Digit mapping:
  - idx 0..3 show current BCD nibbles 0..3.
  - idx 4..7 show best BCD nibbles 0..3 when best_valid, else a dash (seg=7'b0111111).
  - No leading-zero suppression.
  - dp=0 only at idx 1 and idx 5, giving a "XXX.X" format.
- Reset mid-conversion aborts to IDLE and behaves exactly as the reset values above.

Decomposition:
- Package score_disp_pkg:
  - Seven-segment encodings for digits 0-9, DASH and BLANK, active-low, GFEDCBA order (e.g. '0'=7'b1000000, '4'=7'b0011001).
  - BCD_MAX=9999 and CONV_BITS=14.
- Sub-module bin2bcd_seq:
  - Ports: clk, reset, start, bin[13:0], busy, done, bcd[15:0].
  - Reused for both values.
- The top holds the best-time tracker, the conversion sequencer, and the scan/segment mux.

Test Plan:
- Reset with DIGIT_TICKS=4 -> an=8'hFF, seg=7'h7F, dp=1, best_time=0, new_record=0. First digit is lit (an=8'hFE) only after the first scan update.
- timer=1234, no win -> within 34 cycles, scanning shows idx0='4' (7'b0011001), idx1='3' with dp=0, idx2='2', idx3='1'. idx4..7 show dash.
- timer=500, win rises -> best_time=500, new_record high for exactly 1 cycle. Holding won high for 100 cycles produces no further pulse. Left digits show "050.0".
- Subsequent wins (falling edge of won between each):
  - timer=600 -> best_time stays 500, no pulse.
  - timer=500 -> best_time stays 500, no pulse.
  - timer=400 -> best_time=400, pulse.
- timer=12000 -> right digits show 9,9,9,9. Win with no prior best -> best_time=12000, left digits show 9999.
- Reset asserted during SHIFT -> next cycle an=8'hFF, best_time=0, shown registers 0. After release, the first conversion completes 16 cycles after its start.
